// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath handshake and control bundle between the main FSM and the core
interface multicycle_controller_if #(parameter int STATE_W = 4, parameter int CNT_W = 32);
  logic [6:0] op;
  logic zero, mem_ready;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output op, zero, mem_ready,
    input pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
    input result_src, alu_src_a, alu_src_b, alu_op, state, instr_count
  );
  modport slave (
    input op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
    output result_src, alu_src_a, alu_src_b, alu_op, state, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RISC-V core with retired-instruction counter
module multicycle_controller #(
  parameter int STATE_W = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_B = 7'b1100011, OP_J = 7'b1101111;
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  typedef struct packed {
    logic fetch, pc_update, branch, adr_src, mem_write, reg_write, illegal;
    logic [1:0] result_src, src_a, src_b, alu_op;
  } ctl_t;
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin c.fetch = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; end
      DECODE: begin c.src_a = 2'b01; c.src_b = 2'b01; end
      MEMADR: begin c.src_a = 2'b10; c.src_b = 2'b01; end
      MEMREAD: c.adr_src = 1'b1;
      MEMWB: begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB: c.reg_write = 1'b1;
      BEQ: begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JAL: begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction
  state_t st, ns;
  ctl_t ctl;
  logic retire;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    ns = st;
    case (st)
      FETCH: ns = bus.mem_ready ? DECODE : FETCH;
      DECODE: ns = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                   bus.op == OP_R ? EXECUTER :
                   bus.op == OP_I ? EXECUTEI :
                   bus.op == OP_B ? BEQ :
                   bus.op == OP_J ? JAL : TRAP;
      MEMADR: ns = bus.op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD: ns = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: ns = bus.mem_ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: ns = ALUWB;
      TRAP: ns = TRAP;
      default: ns = FETCH;
    endcase
  end
  assign retire = ns == FETCH && (st == MEMWB || st == MEMWRITE || st == ALUWB || st == BEQ);
  // control word is registered from the next state so outputs stay Moore without a decode stage after the flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= FETCH;
      ctl <= decode(FETCH);
      cnt <= '0;
    end else begin
      st <= ns;
      ctl <= decode(ns);
      cnt <= cnt + CNT_W'(retire);
    end
  assign bus.ir_write = ctl.fetch & bus.mem_ready;
  assign bus.pc_write = (ctl.fetch & bus.mem_ready) | ctl.pc_update | (ctl.branch & bus.zero);
  assign bus.adr_src = ctl.adr_src;
  assign bus.mem_write = ctl.mem_write;
  assign bus.reg_write = ctl.reg_write;
  assign bus.illegal = ctl.illegal;
  assign bus.result_src = ctl.result_src;
  assign bus.alu_src_a = ctl.src_a;
  assign bus.alu_src_b = ctl.src_b;
  assign bus.alu_op = ctl.alu_op;
  assign bus.state = st;
  assign bus.instr_count = cnt;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RISC-V core, replacing the single-cycle main decoder.
- Sequences the shared ALU, memory and register file over Fetch/Decode/Execute/Memory/Writeback states.
- Emits 2-bit alu_op for the existing ALU decoder; holds in memory states until mem_ready.
- Counts retired instructions and traps on unsupported opcodes.

Parameters:
STATE_W, 4, width of the state register (12 states used, codes 0..11)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  7  instruction opcode from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register enable
result_src  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
alu_src_a  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1
alu_src_b  output  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4
alu_op  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
reg_write  output  1  register file write enable
illegal  output  1  high while in TRAP
state  output  STATE_W  current state, for debug
instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state = FETCH (0), instr_count = 0. All outputs take FETCH values.
- Reset asserted mid-instruction aborts it immediately. Pending mem_write drops asynchronously.
- Output defaults: every output not listed for a state is 0.
- Derived strobe: pc_write = pc_update | (branch & zero). pc_update and branch are internal.
- Output timing: outputs are Moore (decoded from state), except ir_write and pc_update in FETCH, which also depend on mem_ready.
- States, codes, outputs and next state:
  - 0 FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=mem_ready, pc_update=mem_ready. Next: DECODE if mem_ready, else FETCH.
  - 1 DECODE: a=01, b=01, alu_op=00. Next by op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> TRAP
  - 2 MEMADR: a=10, b=01, alu_op=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - 3 MEMREAD: adr_src=1, result_src=00. Next: MEMWB when mem_ready, else hold.
  - 4 MEMWB: result_src=01, reg_write=1. Next: FETCH.
  - 5 MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays high every cycle until mem_ready. Next: FETCH when mem_ready.
  - 6 EXECUTER: a=10, b=00, alu_op=10. Next: ALUWB.
  - 7 EXECUTEI: a=10, b=01, alu_op=10. Next: ALUWB.
  - 8 ALUWB: result_src=00, reg_write=1. Next: FETCH.
  - 9 BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
  - 10 JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.
  - 11 TRAP: illegal=1, all strobes 0. Sticky until reset.
  - Codes 12..15: next state FETCH, outputs as TRAP. Never entered normally.
- Instruction counter: instr_count increments by 1 on the cycle that leaves for FETCH from:
  - MEMWB
  - MEMWRITE (with mem_ready)
  - ALUWB
  - BEQ
- JAL is counted once, via ALUWB. No increment while in TRAP.
- At 2^CNT_W-1, the next increment wraps to 0.
- Latency in cycles with mem_ready=1 throughout:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - beq: 3
  - jal: 4
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs hold stable while waiting.
- op is sampled only in DECODE and MEMADR. The IR is stable there because ir_write=0.

Test Plan:
- Reset, then mem_ready=1 and op=0110011 -> state sequence 0,1,6,8,0. reg_write high only in state 8. instr_count=1 after 4 cycles.
- lw (0000011) with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total. ir_write pulses once. result_src=01 with reg_write=1 in MEMWB.
- sw (0100011) with mem_ready low for 3 cycles in MEMWRITE -> mem_write high 4 consecutive cycles, adr_src=1, then FETCH. instr_count increments once.
- beq (1100011): zero=1 -> pc_write=1 in BEQ. zero=0 -> pc_write=0. Both pass through 3 states and increment the counter.
- op=1111111 -> TRAP, illegal=1 and held for 20 cycles, counter frozen. reset -> FETCH with illegal=0.
- Force instr_count to 2^CNT_W-1 (CNT_W=4: 15) and retire an instruction -> 0. Assert reset while in MEMWRITE -> mem_write drops the same cycle and the counter clears.
